// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: issues a burst of reads to a FIFO controller.
// IDLE -> READ -> DONE FSM, one read per cycle while the FIFO has data and the
// producer is not writing; a burst is aborted after TIMEOUT consecutive stalls.
// Optional macro FIFO_RD_ACK_CHECK_EN adds a read-acknowledge checker (ack_err).
module fifo_burst_reader #(
    parameter int addresswidth = 5,
    parameter int TIMEOUT      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [addresswidth:0] i_burst_len,
    input  logic                  i_emp,
    input  logic                  i_wr_req,
    input  logic                  i_rd_en,
    output logic                  o_rd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [addresswidth:0] o_rd_count,
    output logic                  o_ack_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [addresswidth:0] CNT_ONE  = 1;
    localparam logic [addresswidth:0] CNT_ZERO = '0;
    localparam logic [7:0]            STALL_LIM = 8'(TIMEOUT);

    state_t                r_state;
    logic [addresswidth:0] r_remaining;
    logic [addresswidth:0] r_rd_count;
    logic [7:0]            r_stall;
    logic                  r_timeout;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_rd;
    logic [7:0]            w_stall_nxt;

    // Read request: writes win over reads, and nothing is issued once the
    // burst has been fully requested.
    assign w_rd = (r_state == S_READ) && !i_emp && !i_wr_req &&
                  (r_remaining != CNT_ZERO);
    assign w_stall_nxt = r_stall + 8'd1;

    // Burst FSM with its counters and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_remaining <= CNT_ZERO;
            r_rd_count  <= CNT_ZERO;
            r_stall     <= 8'd0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rd_count <= CNT_ZERO;
                        r_timeout  <= 1'b0;
                        r_stall    <= 8'd0;
                        r_busy     <= 1'b1;
                        if (i_burst_len != CNT_ZERO) begin
                            r_state     <= S_READ;
                            r_remaining <= i_burst_len;
                            r_done      <= 1'b0;
                        end else begin
                            // Empty burst completes immediately.
                            r_state     <= S_DONE;
                            r_remaining <= CNT_ZERO;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd) begin
                        r_remaining <= r_remaining - CNT_ONE;
                        r_rd_count  <= r_rd_count + CNT_ONE;
                        r_stall     <= 8'd0;
                        if (r_remaining == CNT_ONE) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_stall <= w_stall_nxt;
                        if (w_stall_nxt == STALL_LIM) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately ignored here.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd       = w_rd;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_timeout  = r_timeout;
    assign o_rd_count = r_rd_count;

`ifdef FIFO_RD_ACK_CHECK_EN
    logic r_exp_ack;
    logic r_ack_err;

    // The FIFO must acknowledge exactly the reads issued one cycle earlier.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp_ack <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_exp_ack <= w_rd;
            if (i_rd_en != r_exp_ack)
                r_ack_err <= 1'b1;
        end
    end

    assign o_ack_err = r_ack_err;
`else
    // Acknowledge is not checked in this build.
    logic w_unused_rd_en;
    assign w_unused_rd_en = i_rd_en;
    assign o_ack_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: per-cycle vector table plus hand sequences
// for timeout, reset mid-burst, max burst length and the ack checker.
module tb_fifo_burst_reader;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW:0]   i_burst_len = '0;
    logic          i_emp = 1'b1;
    logic          i_wr_req = 1'b0;
    logic          i_rd_en = 1'b0;
    logic          o_rd, o_busy, o_done, o_timeout, o_ack_err;
    logic [AW:0]   o_rd_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic withhold = 1'b0;

    fifo_burst_reader #(.addresswidth(AW), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_burst_len(i_burst_len),
        .i_emp(i_emp), .i_wr_req(i_wr_req), .i_rd_en(i_rd_en),
        .o_rd(o_rd), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
        .o_rd_count(o_rd_count), .o_ack_err(o_ack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [AW:0] len;
        logic        emp;
        logic        wr;
        logic        rd;
        logic        busy;
        logic        done;
        logic [AW:0] cnt;
        logic        to;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(logic s, int l, logic e, logic w,
                                logic rd, logic b, logic d, int c, logic t);
        vec_t v;
        v.start = s; v.len = 6'(l); v.emp = e; v.wr = w;
        v.rd = rd; v.busy = b; v.done = d; v.cnt = 6'(c); v.to = t;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock; the FIFO model acknowledges every read one cycle later.
    task automatic tick();
        logic r;
        r = o_rd & ~i_rst & ~withhold;
        @(posedge clk);
        #1;
        i_rd_en = r;
    endtask

    task automatic chk_all(string tag, logic rd, logic busy, logic done,
                           int cnt, logic to);
        chk({tag, ".rd"},    int'(o_rd),       int'(rd));
        chk({tag, ".busy"},  int'(o_busy),     int'(busy));
        chk({tag, ".done"},  int'(o_done),     int'(done));
        chk({tag, ".count"}, int'(o_rd_count), cnt);
        chk({tag, ".to"},    int'(o_timeout),  int'(to));
    endtask

    initial begin
        int n;
        int reads;
        logic seen_done;

        // Burst of 4, free-flowing
        tbl[0]  = mk(1, 4, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 1, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 1, 0, 2, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 1, 0, 3, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 1, 4, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 4, 0);
        // Burst of 6, emp toggling 1,0
        tbl[7]  = mk(1, 6, 1, 0, 0, 0, 0, 4, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 0, 1, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 1, 0, 2, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 2, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 1, 0, 3, 0);
        tbl[15] = mk(0, 0, 0, 0, 1, 1, 0, 3, 0);
        tbl[16] = mk(0, 0, 1, 0, 0, 1, 0, 4, 0);
        tbl[17] = mk(0, 0, 0, 0, 1, 1, 0, 4, 0);
        tbl[18] = mk(0, 0, 1, 0, 0, 1, 0, 5, 0);
        tbl[19] = mk(0, 0, 0, 0, 1, 1, 0, 5, 0);
        // DONE cycle with start=1: must be ignored
        tbl[20] = mk(1, 4, 0, 0, 0, 1, 1, 6, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 6, 0);
        // Burst of 3, wr_req on second READ cycle
        tbl[22] = mk(1, 3, 0, 0, 0, 0, 0, 6, 0);
        tbl[23] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0);
        tbl[25] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0);
        tbl[26] = mk(0, 0, 0, 0, 1, 1, 0, 2, 0);
        tbl[27] = mk(0, 0, 0, 0, 0, 1, 1, 3, 0);
        tbl[28] = mk(0, 0, 0, 0, 0, 0, 0, 3, 0);

        // Reset state
        i_rst = 1'b1;
        tick(); tick();
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset.ack_err", int'(o_ack_err), 0);
        i_rst = 1'b0;

        foreach (tbl[i]) begin
            i_start = tbl[i].start; i_burst_len = tbl[i].len;
            i_emp = tbl[i].emp; i_wr_req = tbl[i].wr;
            #2;
            chk_all($sformatf("vec%0d", i), tbl[i].rd, tbl[i].busy,
                    tbl[i].done, int'(tbl[i].cnt), tbl[i].to);
            if (o_rd && i_wr_req) chk($sformatf("vec%0d.rd_wr_excl", i), 1, 0);
            tick();
        end
        i_start = 1'b0; i_emp = 1'b0; i_wr_req = 1'b0;
        chk("ack_err.clean_traffic", int'(o_ack_err), 0);

        // Timeout: 2 reads then emp stuck at 1
        i_start = 1'b1; i_burst_len = 6'd8; tick(); i_start = 1'b0;
        tick(); tick();
        i_emp = 1'b1;
        n = 0;
        #2;
        while (!o_done && n < 40) begin
            if (o_rd) chk("timeout.rd_while_emp", 1, 0);
            tick(); #2; n++;
        end
        chk("timeout.stall_cycles", n, 16);
        chk_all("timeout.done", 0, 1, 1, 2, 1);
        tick(); #2;
        chk_all("timeout.idle_sticky", 0, 0, 0, 2, 1);
        i_emp = 1'b0;

        // Reset mid-burst after 3 reads
        i_start = 1'b1; i_burst_len = 6'd8; tick(); i_start = 1'b0;
        tick(); tick(); tick();
        #2;
        chk("rst_mid.count_before", int'(o_rd_count), 3);
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        #2;
        chk_all("rst_mid.after", 0, 0, 0, 0, 0);
        seen_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); #2;
            if (o_done || o_busy) seen_done = 1'b1;
        end
        chk("rst_mid.no_done", int'(seen_done), 0);
        // Zero-length burst
        i_start = 1'b1; i_burst_len = 6'd0; tick(); i_start = 1'b0;
        #2;
        chk_all("len0.done", 0, 1, 1, 0, 0);
        tick(); #2;
        chk_all("len0.idle", 0, 0, 0, 0, 0);

        // Maximum burst length, no counter wrap
        i_start = 1'b1; i_burst_len = 6'd63; tick(); i_start = 1'b0;
        reads = 0; n = 0;
        #2;
        while (!o_done && n < 100) begin
            if (o_rd) reads++;
            tick(); #2; n++;
        end
        chk("maxlen.reads", reads, 63);
        chk("maxlen.latency", n, 63);
        chk_all("maxlen.done", 0, 1, 1, 63, 0);
        tick();
        chk("maxlen.ack_err", int'(o_ack_err), 0);

        // Withheld acknowledge
        i_start = 1'b1; i_burst_len = 6'd4; tick(); i_start = 1'b0;
        tick();
        withhold = 1'b1; tick(); withhold = 1'b0;
        tick(); tick(); tick(); tick();
        #2;
`ifdef FIFO_RD_ACK_CHECK_EN
        chk("ack.err_set", int'(o_ack_err), 1);
        i_start = 1'b1; i_burst_len = 6'd2; tick(); i_start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2;
        chk("ack.err_sticky", int'(o_ack_err), 1);
`else
        chk("ack.tied_low", int'(o_ack_err), 0);
`endif
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        #2;
        chk("ack.cleared_by_rst", int'(o_ack_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter addresswidth, default 5, FIFO pointer width minus one; the FIFO depth is 2**addresswidth.
REQ-002 Parameter TIMEOUT, default 16, is the number of consecutive stalled cycles in READ that aborts a burst; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  burst request, sampled in IDLE only.
REQ-006 burst_len  input  addresswidth+1  number of reads requested, sampled with start.
REQ-007 emp  input  1  FIFO empty flag from the FIFO controller.
REQ-008 wr_req  input  1  producer intends to write this cycle; has priority over reads.
REQ-009 rd_en  input  1  FIFO read acknowledge, registered one cycle after an accepted read.
REQ-010 rd  output  1  read request to the FIFO controller.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse when a burst ends.
REQ-013 timeout  output  1  sticky flag: the last burst ended by stall timeout.
REQ-014 rd_count  output  addresswidth+1  reads accepted in the current or last burst.
REQ-015 ack_err  output  1  sticky acknowledge-mismatch flag (see REQ-033).

Function
REQ-016 States are IDLE, READ and DONE, binary encoded.
REQ-017 IDLE to READ on start=1 and burst_len!=0; remaining<=burst_len, rd_count<=0, timeout<=0, stall counter<=0.
REQ-018 start with burst_len=0 goes IDLE to DONE directly, with rd_count=0 and timeout=0.
REQ-019 rd is combinational: rd = (state==READ) and !emp and !wr_req and remaining!=0.
REQ-020 rd and wr_req are never both 1 in the same cycle.
REQ-021 An accepted read is a cycle with rd=1 at the rising edge; on it remaining decrements by 1, rd_count increments by 1 and the stall counter clears.
REQ-022 A READ cycle with rd=0 (emp=1 or wr_req=1) increments the stall counter.
REQ-023 READ to DONE at the edge where remaining goes from 1 to 0.
REQ-024 READ to DONE with timeout<=1 when the stall counter reaches TIMEOUT; reads accepted so far remain in rd_count.
REQ-025 DONE asserts done for exactly one cycle, then returns to IDLE unconditionally.
REQ-026 start is ignored outside IDLE, including in the DONE cycle.
REQ-027 rd_count holds its value in IDLE until the next accepted start.
REQ-028 Maximum burst_len is 2**(addresswidth+1)-1; no counter wraps within a burst.
REQ-029 Throughput is one read per cycle while emp=0 and wr_req=0; minimum burst latency is burst_len+1 cycles from start to done.

Reset
REQ-030 rst=1 at a rising edge forces IDLE; rd=0, busy=0, done=0, timeout=0, ack_err=0, rd_count=0, remaining=0, stall counter=0.
REQ-031 rst mid-burst abandons the burst without a done pulse; rd deasserts in the same cycle that state becomes IDLE.
REQ-032 rst has priority over every other input.

Configuration
REQ-033 With macro FIFO_RD_ACK_CHECK_EN defined, the block registers rd into an expected-acknowledge bit and sets ack_err (sticky until rst) in any cycle where rd_en differs from that bit.
REQ-034 Without FIFO_RD_ACK_CHECK_EN, rd_en is unused, no checker logic exists and ack_err is tied to 0.

Verification
REQ-035 Reset, then start with burst_len=4, emp=0, wr_req=0 -> rd high 4 consecutive cycles; done pulses on the 5th cycle after start; rd_count=4; timeout=0.
REQ-036 burst_len=6, emp toggling 1,0 every cycle -> exactly 6 reads accepted, rd never high while emp=1, rd_count=6, no timeout.
REQ-037 burst_len=3, wr_req=1 on the second READ cycle -> rd=0 in that cycle; 3 reads still complete; done is delayed by one cycle.
REQ-038 burst_len=8, emp stuck at 1 after 2 reads, TIMEOUT=16 -> done 16 cycles after the last read; timeout=1; rd_count=2.
REQ-039 rst asserted during READ after 3 reads -> next cycle IDLE, busy=0, rd_count=0, no done pulse; start with burst_len=0 -> done on the next cycle with rd_count=0.
REQ-040 FIFO_RD_ACK_CHECK_EN defined, rd_en withheld one cycle after an accepted read -> ack_err=1 and it stays 1 until rst.
